// File: rtl/iob_axi2iob_burst.sv
// AXI4 slave to IOb master bridge. Each AXI beat becomes one IOb access, with one
// burst in flight and one IOb request outstanding. Reserved bursts answer SLVERR without touching IOb.
module iob_axi2iob_burst #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic [AXI_ID_W-1:0]   axi_awid_i,
    input  logic [ADDR_W-1:0]     axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]  axi_awlen_i,
    input  logic [2:0]            axi_awsize_i,
    input  logic [1:0]            axi_awburst_i,
    input  logic                  axi_awvalid_i,
    output logic                  axi_awready_o,
    input  logic [DATA_W-1:0]     axi_wdata_i,
    input  logic [DATA_W/8-1:0]   axi_wstrb_i,
    input  logic                  axi_wlast_i,
    input  logic                  axi_wvalid_i,
    output logic                  axi_wready_o,
    output logic [AXI_ID_W-1:0]   axi_bid_o,
    output logic [1:0]            axi_bresp_o,
    output logic                  axi_bvalid_o,
    input  logic                  axi_bready_i,
    input  logic [AXI_ID_W-1:0]   axi_arid_i,
    input  logic [ADDR_W-1:0]     axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
    input  logic [2:0]            axi_arsize_i,
    input  logic [1:0]            axi_arburst_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,
    output logic [AXI_ID_W-1:0]   axi_rid_o,
    output logic [DATA_W-1:0]     axi_rdata_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,
    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_RESP} state_t;

    state_t                state_q, state_d;
    logic                  prio_wr_q, prio_wr_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [AXI_LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d, wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic [ADDR_W-1:0]     step, mask, incr_addr, next_addr;
    logic                  last, rsvd, grant_wr, grant_rd;

    assign last = (cnt_q == len_q);
    assign rsvd = (burst_q == 2'b11);

    always_comb begin
        step      = ADDR_W'(1) << size_q;
        incr_addr = addr_q + step;
        mask      = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~mask) | (incr_addr & mask);
            default: next_addr = incr_addr;
        endcase
    end

    // Grants are gated by cke_i so a handshake is never shown while the latches are frozen.
    assign grant_wr = cke_i && axi_awvalid_i && (!axi_arvalid_i || prio_wr_q);
    assign grant_rd = cke_i && axi_arvalid_i && (!axi_awvalid_i || !prio_wr_q);

    always_comb begin
        state_d       = state_q;
        prio_wr_d     = prio_wr_q;
        id_d          = id_q;
        addr_d        = addr_q;
        len_d         = len_q;
        size_d        = size_q;
        burst_d       = burst_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        axi_awready_o = 1'b0;
        axi_arready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        axi_bresp_o   = 2'b00;
        axi_rvalid_o  = 1'b0;
        axi_rlast_o   = 1'b0;
        axi_rresp_o   = 2'b00;
        iob_avalid_o  = 1'b0;
        iob_wstrb_o   = '0;
        case (state_q)
            IDLE: begin
                axi_awready_o = grant_wr;
                axi_arready_o = grant_rd;
                if (grant_wr) begin
                    id_d    = axi_awid_i;
                    addr_d  = axi_awaddr_i;
                    len_d   = axi_awlen_i;
                    size_d  = axi_awsize_i;
                    burst_d = axi_awburst_i;
                    cnt_d   = '0;
                    err_d   = (axi_awburst_i == 2'b11);
                    state_d = WR_DATA;
                    if (axi_arvalid_i) prio_wr_d = 1'b0;
                end else if (grant_rd) begin
                    id_d    = axi_arid_i;
                    addr_d  = axi_araddr_i;
                    len_d   = axi_arlen_i;
                    size_d  = axi_arsize_i;
                    burst_d = axi_arburst_i;
                    cnt_d   = '0;
                    err_d   = (axi_arburst_i == 2'b11);
                    rdata_d = '0;
                    state_d = (axi_arburst_i == 2'b11) ? RD_RESP : RD_REQ;
                    if (axi_awvalid_i) prio_wr_d = 1'b1;
                end
            end
            RD_REQ: begin
                iob_avalid_o = 1'b1;
                if (iob_ready_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (iob_rvalid_i) begin
                    rdata_d = iob_rdata_i;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                axi_rvalid_o = 1'b1;
                axi_rlast_o  = last;
                axi_rresp_o  = err_q ? SLVERR : 2'b00;
                if (axi_rready_i) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = rsvd ? RD_RESP : RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                axi_wready_o = 1'b1;
                if (axi_wvalid_i) begin
                    wdata_d = axi_wdata_i;
                    wstrb_d = axi_wstrb_i;
                    if (axi_wlast_i != last) err_d = 1'b1;
                    if (!rsvd)     state_d = WR_REQ;
                    else if (last) state_d = WR_RESP;
                    else           cnt_d   = cnt_q + 1'b1;
                end
            end
            WR_REQ: begin
                iob_avalid_o = 1'b1;
                iob_wstrb_o  = wstrb_q;
                if (iob_ready_i) begin
                    if (last) begin
                        state_d = WR_RESP;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = WR_DATA;
                    end
                end
            end
            WR_RESP: begin
                axi_bvalid_o = 1'b1;
                axi_bresp_o  = err_q ? SLVERR : 2'b00;
                if (axi_bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign axi_bid_o   = id_q;
    assign axi_rid_o   = id_q;
    assign axi_rdata_o = rdata_q;
    assign iob_addr_o  = addr_q;
    assign iob_wdata_o = wdata_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (cke_i) begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end
endmodule

// File: tb/tb_iob_axi2iob_burst.sv
// Directed bench for iob_axi2iob_burst: a zero-wait IOb slave model logs every accepted
// request and answers reads one cycle after acceptance with an address-derived word.
module tb_iob_axi2iob_burst;
    logic        clk = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        cke_i = 1'b1;
    logic [0:0]  axi_awid_i = '0, axi_arid_i = '0;
    logic [31:0] axi_awaddr_i = '0, axi_araddr_i = '0;
    logic [7:0]  axi_awlen_i = '0, axi_arlen_i = '0;
    logic [2:0]  axi_awsize_i = '0, axi_arsize_i = '0;
    logic [1:0]  axi_awburst_i = '0, axi_arburst_i = '0;
    logic        axi_awvalid_i = 1'b0, axi_arvalid_i = 1'b0;
    logic        axi_awready_o, axi_arready_o;
    logic [31:0] axi_wdata_i = '0;
    logic [3:0]  axi_wstrb_i = '0;
    logic        axi_wlast_i = 1'b0, axi_wvalid_i = 1'b0, axi_wready_o;
    logic [0:0]  axi_bid_o, axi_rid_o;
    logic [1:0]  axi_bresp_o, axi_rresp_o;
    logic        axi_bvalid_o, axi_bready_i = 1'b0;
    logic [31:0] axi_rdata_o;
    logic        axi_rlast_o, axi_rvalid_o, axi_rready_i = 1'b0;
    logic        iob_avalid_o;
    logic [31:0] iob_addr_o, iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i = 1'b1;
    logic        iob_rvalid_i = 1'b0;
    logic [31:0] iob_rdata_i = '0;

    int checks = 0;
    int errors = 0;
    int lg_n = 0;
    logic [31:0] lg_addr [0:255];
    logic [31:0] lg_wdata[0:255];
    logic [3:0]  lg_wstrb[0:255];
    logic [31:0] exp_rd[0:7];
    logic [31:0] wd[0:7];
    logic [3:0]  ws[0:7];

    iob_axi2iob_burst dut (
        .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awsize_i(axi_awsize_i), .axi_awburst_i(axi_awburst_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arsize_i(axi_arsize_i), .axi_arburst_i(axi_arburst_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i),
        .iob_rvalid_i(iob_rvalid_i), .iob_rdata_i(iob_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (iob_avalid_o && iob_ready_i) begin
            lg_addr[lg_n % 256]  <= iob_addr_o;
            lg_wdata[lg_n % 256] <= iob_wdata_o;
            lg_wstrb[lg_n % 256] <= iob_wstrb_o;
            lg_n <= lg_n + 1;
        end
        iob_rvalid_i <= iob_avalid_o && iob_ready_i && (iob_wstrb_o == 4'h0);
        iob_rdata_i  <= (iob_addr_o == 32'h10) ? 32'hDEADBEEF : {16'hA5A5, iob_addr_o[15:0]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        chk({tag, "_addr"}, 64'(lg_addr[idx % 256]), 64'(a));
        chk({tag, "_strb"}, 64'(lg_wstrb[idx % 256]), 64'(s));
        if (s != 4'h0) chk({tag, "_wdata"}, 64'(lg_wdata[idx % 256]), 64'(d));
    endtask

    task automatic ar_send(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        int t = 0;
        axi_arid_i = id; axi_araddr_i = a; axi_arlen_i = len;
        axi_arsize_i = sz; axi_arburst_i = bu; axi_arvalid_i = 1'b1;
        @(negedge clk);
        while (!axi_arready_o && t < 100) begin @(negedge clk); t++; end
        chk("ar_handshake", 64'(t < 100), 64'd1);
        @(posedge clk); #1;
        axi_arvalid_i = 1'b0;
    endtask

    // Collect nb R beats; beat stall_beat is held off for 5 cycles with rready low.
    task automatic r_get(input int nb, input int len, input logic [1:0] resp,
                         input logic [0:0] id, input int stall_beat);
        logic [31:0] snap;
        for (int b = 0; b < nb; b++) begin
            int t = 0;
            axi_rready_i = (b != stall_beat);
            @(negedge clk);
            while (!axi_rvalid_o && t < 100) begin @(negedge clk); t++; end
            chk("r_valid_wait", 64'(t < 100), 64'd1);
            if (b == stall_beat) begin
                snap = axi_rdata_o;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_rvalid", 64'(axi_rvalid_o), 64'd1);
                    chk("stall_rdata", 64'(axi_rdata_o), 64'(snap));
                    chk("stall_no_iob", 64'(iob_avalid_o), 64'd0);
                end
                axi_rready_i = 1'b1;
            end
            chk("r_data", 64'(axi_rdata_o), 64'(exp_rd[b]));
            chk("r_last", 64'(axi_rlast_o), 64'(b == len));
            chk("r_resp", 64'(axi_rresp_o), 64'(resp));
            chk("r_id", 64'(axi_rid_o), 64'(id));
            @(posedge clk); #1;
        end
        axi_rready_i = 1'b0;
    endtask

    task automatic w_burst(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] lastmask,
                           input logic [1:0] bresp);
        int t = 0;
        axi_awid_i = id; axi_awaddr_i = a; axi_awlen_i = len;
        axi_awsize_i = sz; axi_awburst_i = bu; axi_awvalid_i = 1'b1;
        @(negedge clk);
        while (!axi_awready_o && t < 100) begin @(negedge clk); t++; end
        chk("aw_handshake", 64'(t < 100), 64'd1);
        @(posedge clk); #1;
        axi_awvalid_i = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            axi_wdata_i = wd[b]; axi_wstrb_i = ws[b]; axi_wlast_i = lastmask[b];
            axi_wvalid_i = 1'b1;
            @(negedge clk);
            while (!axi_wready_o && t < 100) begin @(negedge clk); t++; end
            chk("w_handshake", 64'(t < 100), 64'd1);
            @(posedge clk); #1;
            axi_wvalid_i = 1'b0;
        end
        t = 0;
        axi_bready_i = 1'b1;
        @(negedge clk);
        while (!axi_bvalid_o && t < 100) begin @(negedge clk); t++; end
        chk("b_valid_wait", 64'(t < 100), 64'd1);
        chk("b_resp", 64'(axi_bresp_o), 64'(bresp));
        chk("b_id", 64'(axi_bid_o), 64'(id));
        @(posedge clk); #1;
        axi_bready_i = 1'b0;
    endtask

    initial begin
        int base;
        #1;
        chk("rst_awready", 64'(axi_awready_o), 64'd0);
        chk("rst_arready", 64'(axi_arready_o), 64'd0);
        chk("rst_rvalid", 64'(axi_rvalid_o), 64'd0);
        chk("rst_bvalid", 64'(axi_bvalid_o), 64'd0);
        chk("rst_avalid", 64'(iob_avalid_o), 64'd0);
        chk("rst_addr", 64'(iob_addr_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 arst_n_i = 1'b1;
        @(posedge clk); #1;

        // single read
        base = lg_n;
        exp_rd[0] = 32'hDEADBEEF;
        ar_send(1'b1, 32'h10, 8'd0, 3'd2, 2'b01);
        r_get(1, 0, 2'b00, 1'b1, -1);
        chk("t1_iob_count", 64'(lg_n - base), 64'd1);
        chk_log("t1", base, 32'h10, 4'h0, 32'h0);

        // INCR read with a stall on beat 2
        base = lg_n;
        exp_rd[0] = 32'hA5A50100; exp_rd[1] = 32'hA5A50104;
        exp_rd[2] = 32'hA5A50108; exp_rd[3] = 32'hA5A5010C;
        ar_send(1'b0, 32'h100, 8'd3, 3'd2, 2'b01);
        r_get(4, 3, 2'b00, 1'b0, 1);
        chk("incr_iob_count", 64'(lg_n - base), 64'd4);
        chk_log("incr0", base,     32'h100, 4'h0, 32'h0);
        chk_log("incr1", base + 1, 32'h104, 4'h0, 32'h0);
        chk_log("incr2", base + 2, 32'h108, 4'h0, 32'h0);
        chk_log("incr3", base + 3, 32'h10C, 4'h0, 32'h0);

        // WRAP write: 0x38, 0x3C, 0x30, 0x34
        base = lg_n;
        wd[0] = 32'hC0DE0000; wd[1] = 32'hC0DE0001; wd[2] = 32'hC0DE0002; wd[3] = 32'hC0DE0003;
        ws[0] = 4'hF; ws[1] = 4'h3; ws[2] = 4'hC; ws[3] = 4'h1;
        w_burst(1'b1, 32'h38, 8'd3, 3'd2, 2'b10, 8'b1000, 2'b00);
        chk("wrap_iob_count", 64'(lg_n - base), 64'd4);
        chk_log("wrap0", base,     32'h38, 4'hF, 32'hC0DE0000);
        chk_log("wrap1", base + 1, 32'h3C, 4'h3, 32'hC0DE0001);
        chk_log("wrap2", base + 2, 32'h30, 4'hC, 32'hC0DE0002);
        chk_log("wrap3", base + 3, 32'h34, 4'h1, 32'hC0DE0003);

        // FIXED write with wlast on the first beat
        base = lg_n;
        wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; ws[0] = 4'hF; ws[1] = 4'hF;
        w_burst(1'b0, 32'h20, 8'd1, 3'd2, 2'b00, 8'b01, 2'b10);
        chk("fixed_iob_count", 64'(lg_n - base), 64'd2);
        chk_log("fixed0", base,     32'h20, 4'hF, 32'h12345678);
        chk_log("fixed1", base + 1, 32'h20, 4'hF, 32'h9ABCDEF0);

        // AW and AR together: write wins first, read wins the repeat
        base = lg_n;
        wd[0] = 32'hAAAA5555; ws[0] = 4'hF;
        exp_rd[0] = 32'hA5A50044;
        fork
            w_burst(1'b1, 32'h40, 8'd0, 3'd2, 2'b01, 8'b1, 2'b00);
            begin ar_send(1'b0, 32'h44, 8'd0, 3'd2, 2'b01); r_get(1, 0, 2'b00, 1'b0, -1); end
        join
        chk("arb1_count", 64'(lg_n - base), 64'd2);
        chk_log("arb1_first", base,     32'h40, 4'hF, 32'hAAAA5555);
        chk_log("arb1_second", base + 1, 32'h44, 4'h0, 32'h0);
        base = lg_n;
        wd[0] = 32'h5555AAAA;
        exp_rd[0] = 32'hA5A50048;
        fork
            w_burst(1'b1, 32'h4C, 8'd0, 3'd2, 2'b01, 8'b1, 2'b00);
            begin ar_send(1'b0, 32'h48, 8'd0, 3'd2, 2'b01); r_get(1, 0, 2'b00, 1'b0, -1); end
        join
        chk("arb2_count", 64'(lg_n - base), 64'd2);
        chk_log("arb2_first", base,     32'h48, 4'h0, 32'h0);
        chk_log("arb2_second", base + 1, 32'h4C, 4'hF, 32'h5555AAAA);

        // reserved burst read
        base = lg_n;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        ar_send(1'b1, 32'h80, 8'd1, 3'd2, 2'b11);
        r_get(2, 1, 2'b10, 1'b1, -1);
        chk("rsvd_no_iob", 64'(lg_n - base), 64'd0);

        // reset in the middle of a len=7 read
        exp_rd[0] = 32'hA5A50200; exp_rd[1] = 32'hA5A50204;
        ar_send(1'b0, 32'h200, 8'd7, 3'd2, 2'b01);
        r_get(2, 7, 2'b00, 1'b0, -1);
        arst_n_i = 1'b0;
        #1;
        chk("abort_rvalid", 64'(axi_rvalid_o), 64'd0);
        chk("abort_rlast", 64'(axi_rlast_o), 64'd0);
        chk("abort_rdata", 64'(axi_rdata_o), 64'd0);
        chk("abort_avalid", 64'(iob_avalid_o), 64'd0);
        chk("abort_wready", 64'(axi_wready_o), 64'd0);
        chk("abort_bvalid", 64'(axi_bvalid_o), 64'd0);
        chk("abort_addr", 64'(iob_addr_o), 64'd0);
        @(posedge clk); #1;
        arst_n_i = 1'b1;
        @(posedge clk); #1;
        base = lg_n;
        exp_rd[0] = 32'hDEADBEEF;
        ar_send(1'b1, 32'h10, 8'd0, 3'd2, 2'b01);
        r_get(1, 0, 2'b00, 1'b1, -1);
        chk("post_rst_count", 64'(lg_n - base), 64'd1);
        chk_log("post_rst", base, 32'h10, 4'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
